stopwatch_mux_n: RTL and testbench

STOPWATCH_MUX_N -- requirements
Module: stopwatch_mux_n

---
 rtl/stopwatch_mux_n.sv | 232 +++++++++++++++++++++++
 tb/tb_stopwatch_mux_n.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mux_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stopwatch_mux_n                                                 |
// | Function : BCD stopwatch with start/stop/clear buttons and a time-         |
// |            multiplexed, active-low 7-segment display of NUM_DIGITS digits. |
// | Option   : STOPWATCH_LAP_HOLD_EN adds a lap button that freezes the        |
// |            display on a snapshot while counting continues.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stopwatch_mux_n #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000000,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_stop,
    input  logic                  clear,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp,
    output logic                  running,
    output logic                  overflow
`ifdef STOPWATCH_LAP_HOLD_EN
    ,
    input  logic                  lap,
    output logic                  lap_active
`endif
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef STOPWATCH_LAP_HOLD_EN
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               ss_pulse, clr_pulse;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [3:0]         digits_q [NUM_DIGITS];
    logic [3:0]         digits_d [NUM_DIGITS];
    logic               overflow_q, overflow_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic               dp_q, dp_d;
    logic               running_q, running_d;
    logic [3:0]         shown_digit;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic               lap_pulse;
    logic               lap_active_q, lap_active_d;
    logic [3:0]         snap_q [NUM_DIGITS];
    logic [3:0]         snap_d [NUM_DIGITS];
    assign btn_raw   = {lap, clear, start_stop};
    assign lap_pulse = btn_pulse[2];
`else
    assign btn_raw   = {clear, start_stop};
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Synchronizer flops reset high so a button held through reset gives no edge.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        btn_pulse = sync2_q & ~prev_q;
        ss_pulse  = btn_pulse[0];
        clr_pulse = btn_pulse[1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ss_pulse && !clr_pulse) state_d = S_RUN;
            S_RUN:   if (ss_pulse) state_d = S_PAUSE;
            S_PAUSE: begin
                if (clr_pulse)     state_d = S_IDLE;
                else if (ss_pulse) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        running_d = (state_d == S_RUN);
    end

    always_comb begin
        logic carry;
        tick_d     = tick_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        carry      = 1'b0;
        if (state_q == S_RUN) begin
            if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                tick_d = '0;
                carry  = 1'b1;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (digits_q[i] == 4'd9) begin
                    digits_d[i] = 4'd0;
                end else begin
                    digits_d[i] = digits_q[i] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) overflow_d = 1'b1;
        if (state_d == S_IDLE) begin
            tick_d     = '0;
            overflow_d = 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = 4'd0;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    always_comb begin
        lap_active_d = lap_active_q;
        snap_d       = snap_q;
        if (lap_pulse && state_q == S_RUN) begin
            lap_active_d = ~lap_active_q;
            if (!lap_active_q) snap_d = digits_q;
        end else if (lap_pulse && state_q == S_PAUSE) begin
            lap_active_d = 1'b0;
        end
        if (state_d == S_IDLE) lap_active_d = 1'b0;
    end
`endif

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end
`ifdef STOPWATCH_LAP_HOLD_EN
        shown_digit = lap_active_q ? snap_q[scan_idx_q] : digits_q[scan_idx_q];
`else
        shown_digit = digits_q[scan_idx_q];
`endif
        seg_d = seg_decode(shown_digit);
        an_d  = ~(NUM_DIGITS'(1) << scan_idx_q);
        dp_d  = ~((NUM_DIGITS > 2) && (scan_idx_q == IDX_W'(2)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            prev_q     <= '1;
            state_q    <= S_IDLE;
            tick_q     <= '0;
            overflow_q <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            seg_q      <= 7'b1111111;
            an_q       <= '1;
            dp_q       <= 1'b1;
            running_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 4'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            overflow_q <= overflow_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
            running_q  <= running_d;
            digits_q   <= digits_d;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_active_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= 4'd0;
        end else begin
            lap_active_q <= lap_active_d;
            snap_q       <= snap_d;
        end
    end
    assign lap_active = lap_active_q;
`endif

    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = dp_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_mux_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stopwatch_mux_n                                              |
// | Function : self-checking bench for stopwatch_mux_n (4 digits, fast divs).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_stopwatch_mux_n;

    localparam int ND = 4;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam int MI = 0, MR = 1, MP = 2;
    localparam logic [14:0] RST_VEC = {7'h7f, 4'hf, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ss = 1'b0, cl = 1'b0, lp = 1'b0;
    logic [6:0] seg;
    logic [ND-1:0] an;
    logic dp, running, overflow, lap_obs;
    logic [14:0] obs, m_vec;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: counting is derived from the number of RUN cycles
    int m_state, m_run, m_cyc, m_snap;
    bit m_lap_on, m_running, m_ovf, m_dp;
    logic [6:0] m_seg;
    logic [3:0] m_an;
    bit [2:0] h_ss, h_cl, h_lp;

    always #5 clk = ~clk;

    stopwatch_mux_n #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .start_stop(ss), .clear(cl),
        .seg(seg), .an(an), .dp(dp), .running(running), .overflow(overflow)
`ifdef STOPWATCH_LAP_HOLD_EN
        , .lap(lp), .lap_active(lap_obs)
`endif
    );
`ifndef STOPWATCH_LAP_HOLD_EN
    assign lap_obs = 1'b0;
`endif

    assign obs   = {seg, an, dp, running, overflow, lap_obs};
    assign m_vec = {m_seg, m_an, m_dp, m_running, m_ovf, m_lap_on};

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
            3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
            6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
            9: return 7'b0010000; default: return 7'b1111111;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin : ref_model
        int cnt, shown, idx, nxt;
        bit ssp, clp, lpp;
        if (!rst) begin
            m_state = MI; m_run = 0; m_cyc = 0; m_snap = 0; m_lap_on = 0;
            m_seg = 7'h7f; m_an = 4'hf; m_dp = 1; m_running = 0; m_ovf = 0;
            h_ss = 3'b111; h_cl = 3'b111; h_lp = 3'b111;
        end else begin
            cnt   = (m_run / TD) % pow10(ND);
            shown = m_lap_on ? m_snap : cnt;
            idx   = (m_cyc / SD) % ND;
            m_seg = glyph((shown / pow10(idx)) % 10);
            m_an  = ~(4'(1) << idx);
            m_dp  = (idx != 2);
            ssp = h_ss[1] & ~h_ss[2];
            clp = h_cl[1] & ~h_cl[2];
`ifdef STOPWATCH_LAP_HOLD_EN
            lpp = h_lp[1] & ~h_lp[2];
`else
            lpp = 1'b0;
`endif
            nxt = m_state;
            case (m_state)
                MI: if (ssp && !clp) nxt = MR;
                MR: if (ssp) nxt = MP;
                default: if (clp) nxt = MI; else if (ssp) nxt = MR;
            endcase
            if (lpp && m_state == MR) begin
                if (!m_lap_on) m_snap = cnt;
                m_lap_on = !m_lap_on;
            end else if (lpp && m_state == MP) begin
                m_lap_on = 0;
            end
            if (m_state == MR) m_run++;
            if (nxt == MI) begin m_run = 0; m_lap_on = 0; end
            m_ovf = (m_run / TD) >= pow10(ND);
            m_state = nxt;
            m_running = (nxt == MR);
            m_cyc++;
            h_ss = {h_ss[1:0], ss};
            h_cl = {h_cl[1:0], cl};
            h_lp = {h_lp[1:0], lp};
        end
    end

    // Called at a negedge; buttons are released at a later negedge.
    task automatic press(input bit s, input bit c, input bit l);
        ss = s; cl = c; lp = l;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        ss = 0; cl = 0; lp = 0;
    endtask

    task automatic go_idle();
        if (m_state == MR) begin press(1, 0, 0); repeat (4) @(negedge clk); end
        if (m_state == MP) begin press(0, 1, 0); repeat (4) @(negedge clk); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== RST_VEC) begin n_fail++; $display("FAIL reset_values: got %b want %b", obs, RST_VEC); end
        rst = 1;
        @(negedge clk);
        n_tests++;
        if (seg !== 7'b1000000 || an !== 4'b1110) begin
            n_fail++; $display("FAIL reset_release: seg=%b an=%b want 1000000 1110", seg, an);
        end
        repeat (10) begin
            @(negedge clk); n_tests++;
            if (obs !== m_vec) begin n_fail++; $display("FAIL idle_track: got %b want %b", obs, m_vec); end
        end
    endtask

    task automatic test_run();
        int g = 0;
        press(1, 0, 0);
        while (m_run < 160 && g < 400) begin
            @(negedge clk); g++; n_tests++;
            if (obs !== m_vec) begin n_fail++; $display("FAIL run_track: got %b want %b", obs, m_vec); end
        end
        n_tests++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL run_running: got %b want 1", running); end
        press(1, 0, 0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < ND * SD; k++) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) if (an === ~(4'(1) << i)) begin
                n_tests++;
                if (seg !== glyph((40 / pow10(i)) % 10) || dp !== (i != 2)) begin
                    n_fail++; $display("FAIL run_digits: digit %0d seg=%b dp=%b want %b", i, seg, dp, glyph((40 / pow10(i)) % 10));
                end
            end
        end
        go_idle();
    endtask

    task automatic test_pause_resume();
        int g = 0;
        press(1, 0, 0);
        while (m_run < 3 && g < 20) begin @(negedge clk); g++; end
        press(1, 0, 0);
        repeat (100) begin
            @(negedge clk); n_tests++;
            if (obs !== m_vec) begin n_fail++; $display("FAIL pause_track: got %b want %b", obs, m_vec); end
        end
        for (int k = 0; k < ND * SD; k++) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) if (an === ~(4'(1) << i)) begin
                n_tests++;
                if (seg !== glyph(i == 0 ? 1 : 0)) begin
                    n_fail++; $display("FAIL pause_digits: digit %0d seg=%b want %b", i, seg, glyph(i == 0 ? 1 : 0));
                end
            end
        end
        press(1, 0, 0);
        repeat (30) begin
            @(negedge clk); n_tests++;
            if (obs !== m_vec) begin n_fail++; $display("FAIL resume_track: got %b want %b", obs, m_vec); end
        end
        go_idle();
    endtask

    task automatic test_overflow();
        int g = 0;
        press(1, 0, 0);
        while (m_run < 40008 && g < 41000) begin
            @(negedge clk); g++; n_tests++;
            if (obs !== m_vec) begin n_fail++; $display("FAIL wrap_track: got %b want %b", obs, m_vec); end
        end
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b want 1", overflow); end
        press(0, 1, 0);
        repeat (8) @(negedge clk);
        n_tests++;
        if (running !== 1'b1 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL clear_in_run: running=%b overflow=%b want 1 1", running, overflow);
        end
        press(1, 0, 0);
        repeat (5) @(negedge clk);
        press(0, 1, 0);
        repeat (5) @(negedge clk);
        n_tests++;
        if (running !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL clear_in_pause: running=%b overflow=%b want 0 0", running, overflow);
        end
        for (int k = 0; k < ND * SD; k++) begin
            @(negedge clk); n_tests++;
            if (seg !== 7'b1000000) begin n_fail++; $display("FAIL cleared_digits: seg=%b want 1000000", seg); end
        end
    endtask

    task automatic test_held_reset();
        int g = 0;
        rst = 0; ss = 1; cl = 1;
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (12) begin
            @(negedge clk); n_tests++;
            if (obs !== m_vec) begin n_fail++; $display("FAIL held_track: got %b want %b", obs, m_vec); end
        end
        n_tests++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL held_no_pulse: running=%b want 0", running); end
        ss = 0; cl = 0;
        repeat (3) @(negedge clk);
        press(1, 0, 0);
        while (running !== 1'b1 && g < 10) begin @(negedge clk); g++; end
        n_tests++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL held_repress: running=%b want 1", running); end
        go_idle();
    endtask

`ifdef STOPWATCH_LAP_HOLD_EN
    task automatic test_lap();
        int g = 0;
        press(1, 0, 0);
        while (m_run < 48 && g < 100) begin @(negedge clk); g++; end
        press(0, 0, 1);
        while (m_run < 100 && g < 300) begin
            @(negedge clk); g++; n_tests++;
            if (obs !== m_vec) begin n_fail++; $display("FAIL lap_track: got %b want %b", obs, m_vec); end
        end
        n_tests++;
        if (lap_obs !== 1'b1) begin n_fail++; $display("FAIL lap_on: lap_active=%b want 1", lap_obs); end
        for (int k = 0; k < ND * SD; k++) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) if (an === ~(4'(1) << i)) begin
                n_tests++;
                if (seg !== glyph((12 / pow10(i)) % 10)) begin
                    n_fail++; $display("FAIL lap_frozen: digit %0d seg=%b want %b", i, seg, glyph((12 / pow10(i)) % 10));
                end
            end
        end
        while (m_run < 120 && g < 400) begin @(negedge clk); g++; end
        press(0, 0, 1);
        repeat (6) @(negedge clk);
        n_tests++;
        if (lap_obs !== 1'b0) begin n_fail++; $display("FAIL lap_off: lap_active=%b want 0", lap_obs); end
        repeat (20) begin
            @(negedge clk); n_tests++;
            if (obs !== m_vec) begin n_fail++; $display("FAIL lap_live: got %b want %b", obs, m_vec); end
        end
        go_idle();
    endtask
`endif

    task automatic test_reset_mid_run();
        int g = 0;
        press(1, 0, 0);
        while (m_run < 228 && g < 400) begin
            @(negedge clk); g++; n_tests++;
            if (obs !== m_vec) begin n_fail++; $display("FAIL midrun_track: got %b want %b", obs, m_vec); end
        end
        #3 rst = 0;
        #1 n_tests++;
        if (obs !== RST_VEC) begin n_fail++; $display("FAIL midrun_reset_now: got %b want %b", obs, RST_VEC); end
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== RST_VEC) begin n_fail++; $display("FAIL midrun_reset_held: got %b want %b", obs, RST_VEC); end
        rst = 1;
        @(negedge clk);
        n_tests++;
        if (seg !== 7'b1000000 || an !== 4'b1110 || running !== 1'b0) begin
            n_fail++; $display("FAIL midrun_release: seg=%b an=%b run=%b want 1000000 1110 0", seg, an, running);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: press(1, 0, 0);
                1: press(0, 1, 0);
                2: press(1, 1, 0);
                default: press(0, 0, 1);
            endcase
            repeat ($urandom_range(3, 30)) begin
                @(negedge clk); n_tests++;
                if (obs !== m_vec) begin n_fail++; $display("FAIL random_track: got %b want %b", obs, m_vec); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause_resume();
        test_overflow();
        test_held_reset();
`ifdef STOPWATCH_LAP_HOLD_EN
        test_lap();
`endif
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
